morph_3x3_1bit: RTL and testbench
=================================

// Module: morph_3x3_1bit
// PURPOSE
//  Downstream consumer of the 1-bit 3x3 window stream (win_en + p11..p33) on the
//  SOBEL binary path. Computes binary erosion (9-input AND) or dilation (9-input OR)
//  per window and emits a 1-bit pixel stream with a 2-cycle pipeline latency.
//  Tracks beat position per frame for border handling and an end-of-frame pulse.
//  Feeds the VGA pixel mux or a second cascaded morph stage.
// PARAMETERS
//  CNT_COL_MAX  16'd1023  last column index of a line (line width - 1)
//  CNT_ROW_MAX  16'd767   last row index of a frame (frame height - 1)
// PORTS
//  clk         in   1  pixel clock; the only clock
//  rst         in   1  asynchronous, active-high reset
//  mode        in   1  0 = erosion, 1 = dilation; sampled at frame start only
//  win_en      in   1  window valid strobe from the 3x3 window generator
//  win_data    in   9  {p11,p12,p13,p21,p22,p23,p31,p32,p33}
//  morph_en    out  1  output pixel valid
//  morph_data  out  1  output pixel, 1 = foreground
//  frame_done  out  1  one-cycle pulse coincident with last output beat of frame
// BEHAVIOUR
//  - Reset (async, rst=1): morph_en=0, morph_data=0, frame_done=0, counters=0,
//    pipeline valids=0, latched mode=0 (erosion). Reset mid-frame discards the
//    in-flight beats; the next accepted beat is row 0, col 0.
//  - Stage 1 (win_en=1): register per-row reductions r0..r2 (3-input AND if
//    mode_q=0, OR if mode_q=1) plus valid v1 and border flag b1.
//  - Stage 2: morph_data <= reduction of r0..r2 (same op), morph_en <= v1.
//    Latency exactly 2 clocks from win_en beat to morph_en; one beat per clock max.
//  - Gaps: win_en=0 inserts a bubble; bubbles propagate (morph_en=0, morph_data
//    holds its last value). No backpressure; the downstream must accept every beat.
//  - Counters col/row advance only on win_en. col wraps CNT_COL_MAX->0 and
//    increments row; at row=CNT_ROW_MAX, col=CNT_COL_MAX both wrap to 0.
//  - mode_q loads from mode on a win_en beat with col=0,row=0; mode changes
//    mid-frame have no effect until the next frame.
//  - frame_done=1 for exactly one cycle, same cycle as morph_en of beat
//    (CNT_ROW_MAX, CNT_COL_MAX); 0 otherwise.
//  - Border beat: col==0 | col==CNT_COL_MAX | row==0 | row==CNT_ROW_MAX.
//  - win_data with win_en=0 is don't-care and never affects outputs.
// CONFIGURATION
//  MORPH_BORDER_MASK_EN defined: border beats output morph_data=0 regardless of
//    window contents (still with morph_en=1, same latency).
//  MORPH_BORDER_MASK_EN undefined: border beats output the raw reduction;
//    border flag logic is not synthesised.
// TESTING  (CNT_COL_MAX=7, CNT_ROW_MAX=5 unless stated)
//  1 mode=0, frame of win_data=9'h1FF except beat (2,3)=9'h1EF -> morph_data=1 all
//    interior beats except (2,3)=0; morph_en trails win_en by exactly 2 clocks.
//  2 mode=1, all-zero frame except beat (3,4)=9'h010 -> morph_data=0 everywhere
//    except (3,4)=1; frame_done pulses once, with morph_en of beat (5,7).
//  3 win_en toggled 1,0,1,0 with win_data=9'h1FF, mode=0 -> morph_en=1,0,1,0
//    delayed 2 clocks; morph_data stays 1; counters advance by 2 only.
//  4 mode switched 0->1 at beat (2,0) -> erosion applies rest of frame; dilation
//    from beat (0,0) of next frame.
//  5 rst asserted at beat (3,5) for 1 cycle -> outputs 0 same cycle; next win_en
//    treated as (0,0); frame_done after 48 more beats, not earlier.
//  6 With MORPH_BORDER_MASK_EN, all-ones frame, mode=0 -> 0 on rows 0/5 and
//    cols 0/7, 1 elsewhere; without macro -> 1 on every beat.

Source files
------------

// File: rtl/morph_3x3_1bit.sv
// Binary 3x3 erosion (AND) / dilation (OR) over a 1-bit window stream, 2-cycle latency.
// Optional feature macro: MORPH_BORDER_MASK_EN forces border beats to output 0.
module morph_3x3_1bit #(
    parameter logic [15:0] CNT_COL_MAX = 16'd1023,
    parameter logic [15:0] CNT_ROW_MAX = 16'd767
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode,
    input  logic       win_en,
    input  logic [8:0] win_data,
    output logic       morph_en,
    output logic       morph_data,
    output logic       frame_done
);

    function automatic logic reduce3(input logic op, input logic [2:0] bits);
        logic res;
        case (op)
            1'b0:    res = &bits;
            1'b1:    res = |bits;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    logic [15:0] col_r;
    logic [15:0] row_r;
    logic [15:0] col_nxt_s;
    logic [15:0] row_nxt_s;
    logic        col_last_s;
    logic        row_last_s;
    logic        first_s;
    logic        mode_r;
    logic        mode_eff_s;
    logic [2:0]  red_s;
    logic [2:0]  red_r;
    logic        v1_r;
    logic        m1_r;
    logic        last1_r;
    logic        out_bit_s;
    logic        morph_en_r;
    logic        morph_data_r;
    logic        frame_done_r;
`ifdef MORPH_BORDER_MASK_EN
    logic        border_s;
    logic        b1_r;
`endif

    // Beat position decode and next counter values
    always_comb begin
        col_last_s = (col_r == CNT_COL_MAX);
        row_last_s = (row_r == CNT_ROW_MAX);
        first_s    = (col_r == 16'd0) && (row_r == 16'd0);
        col_nxt_s  = col_r;
        row_nxt_s  = row_r;
        if (col_last_s) begin
            col_nxt_s = 16'd0;
            if (row_last_s) begin
                row_nxt_s = 16'd0;
            end else begin
                row_nxt_s = row_r + 16'd1;
            end
        end else begin
            col_nxt_s = col_r + 16'd1;
            row_nxt_s = row_r;
        end
    end

    // The first beat of a frame already uses the freshly sampled mode
    always_comb begin
        mode_eff_s = mode_r;
        if (first_s) begin
            mode_eff_s = mode;
        end else begin
            mode_eff_s = mode_r;
        end
        red_s[2] = reduce3(mode_eff_s, win_data[8:6]);
        red_s[1] = reduce3(mode_eff_s, win_data[5:3]);
        red_s[0] = reduce3(mode_eff_s, win_data[2:0]);
    end

`ifdef MORPH_BORDER_MASK_EN
    // Border classification of the current beat
    always_comb begin
        border_s = (col_r == 16'd0) || col_last_s || (row_r == 16'd0) || row_last_s;
    end
`endif

    // Beat position counters, advanced only on accepted beats
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_r <= 16'd0;
            row_r <= 16'd0;
        end else if (win_en) begin
            col_r <= col_nxt_s;
            row_r <= row_nxt_s;
        end
    end

    // Frame mode latch, sampled only on the first beat of a frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_r <= 1'b0;
        end else if (win_en && first_s) begin
            mode_r <= mode;
        end
    end

    // Stage 1: per-row reductions plus side-band flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            red_r   <= 3'b000;
            v1_r    <= 1'b0;
            m1_r    <= 1'b0;
            last1_r <= 1'b0;
        end else if (win_en) begin
            red_r   <= red_s;
            v1_r    <= 1'b1;
            m1_r    <= mode_eff_s;
            last1_r <= col_last_s && row_last_s;
        end else begin
            v1_r    <= 1'b0;
            last1_r <= 1'b0;
        end
    end

`ifdef MORPH_BORDER_MASK_EN
    // Stage 1 border flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b1_r <= 1'b0;
        end else if (win_en) begin
            b1_r <= border_s;
        end
    end

    // Stage 2 value with border beats forced to background
    always_comb begin
        if (b1_r) begin
            out_bit_s = 1'b0;
        end else begin
            out_bit_s = reduce3(m1_r, red_r);
        end
    end
`else
    // Stage 2 value, raw reduction on every beat
    always_comb begin
        out_bit_s = reduce3(m1_r, red_r);
    end
`endif

    // Stage 2: output registers; data holds across bubbles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            morph_en_r   <= 1'b0;
            morph_data_r <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            morph_en_r   <= v1_r;
            frame_done_r <= v1_r && last1_r;
            if (v1_r) begin
                morph_data_r <= out_bit_s;
            end
        end
    end

    assign morph_en   = morph_en_r;
    assign morph_data = morph_data_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_morph_3x3_1bit.sv
// Scoreboard bench for morph_3x3_1bit with an 8x6 frame; honours MORPH_BORDER_MASK_EN.
module tb_morph_3x3_1bit;

    logic       clk;
    logic       rst;
    logic       mode;
    logic       win_en;
    logic [8:0] win_data;
    logic       morph_en;
    logic       morph_data;
    logic       frame_done;

    int         checks;
    int         failures;
    logic [1:0] sb_q[$];
    logic [1:0] en_pipe;
    int         col_m;
    int         row_m;
    logic       mode_m;
    logic       last_data;
    int         done_cnt;
    int         done_exp;

    morph_3x3_1bit #(
        .CNT_COL_MAX(16'd7),
        .CNT_ROW_MAX(16'd5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .win_en    (win_en),
        .win_data  (win_data),
        .morph_en  (morph_en),
        .morph_data(morph_data),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle (beat or bubble), update the model, then check outputs.
    task automatic step(input logic en, input logic [8:0] d);
        logic       e;
        logic       last;
        logic [1:0] ent;
        win_en   = en;
        win_data = d;
        if (en) begin
            if (col_m == 0 && row_m == 0) mode_m = mode;
            e    = mode_m ? (d != 9'h000) : (d == 9'h1FF);
`ifdef MORPH_BORDER_MASK_EN
            if (col_m == 0 || col_m == 7 || row_m == 0 || row_m == 5) e = 1'b0;
`endif
            last = (row_m == 5) && (col_m == 7);
            sb_q.push_back({e, last});
            if (last) done_exp++;
            if (col_m == 7) begin
                col_m = 0;
                row_m = (row_m == 5) ? 0 : row_m + 1;
            end else begin
                col_m = col_m + 1;
            end
        end
        en_pipe = {en_pipe[0], en};
        @(posedge clk);
        #1;
        check("morph_en", 16'(morph_en), 16'(en_pipe[1]));
        if (frame_done === 1'b1) done_cnt++;
        if (en_pipe[1]) begin
            if (sb_q.size() > 0) begin
                ent = sb_q.pop_front();
                check("morph_data", 16'(morph_data), 16'(ent[1]));
                check("frame_done", 16'(frame_done), 16'(ent[0]));
                last_data = ent[1];
            end else begin
                checks++;
                failures++;
                $error("FAIL scoreboard_underflow observed=0 expected=1");
            end
        end else begin
            check("data_hold", 16'(morph_data), 16'(last_data));
            check("frame_done_idle", 16'(frame_done), 16'd0);
        end
    endtask

    task automatic do_reset();
        win_en = 1'b0;
        rst    = 1'b1;
        #1;
        check("rst_morph_en", 16'(morph_en), 16'd0);
        check("rst_morph_data", 16'(morph_data), 16'd0);
        check("rst_frame_done", 16'(frame_done), 16'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        sb_q.delete();
        en_pipe   = 2'b00;
        col_m     = 0;
        row_m     = 0;
        mode_m    = 1'b0;
        last_data = 1'b0;
    endtask

    function automatic logic [8:0] rand_win();
        logic [8:0] v;
        v = 9'($urandom);
        if ($urandom_range(0, 2) == 0) v = 9'h1FF;
        if ($urandom_range(0, 3) == 0) v = 9'h000;
        return v;
    endfunction

    initial begin
        clk = 1'b0; rst = 1'b1; mode = 1'b0; win_en = 1'b0; win_data = 9'h000;
        checks = 0; failures = 0; done_cnt = 0; done_exp = 0;
        en_pipe = 2'b00; col_m = 0; row_m = 0; mode_m = 1'b0; last_data = 1'b0;
        #2;
        do_reset();

        // Erosion, all ones except one hole at (2,3)
        mode = 1'b0;
        for (int i = 0; i < 48; i++)
            step(1'b1, (row_m == 2 && col_m == 3) ? 9'h1EF : 9'h1FF);

        // Dilation, all zeros except a single centre pixel at (3,4)
        mode = 1'b1;
        for (int i = 0; i < 48; i++)
            step(1'b1, (row_m == 3 && col_m == 4) ? 9'h010 : 9'h000);

        // Bubbles with garbage data, then the remainder of the frame
        mode = 1'b0;
        step(1'b1, 9'h1FF);
        step(1'b0, 9'($urandom));
        step(1'b1, 9'h1FF);
        step(1'b0, 9'($urandom));
        for (int i = 0; i < 46; i++) step(1'b1, 9'h1FF);

        // Mode flips mid-frame: erosion holds until the next frame
        mode = 1'b0;
        for (int i = 0; i < 48; i++) begin
            if (row_m == 2 && col_m == 0) mode = 1'b1;
            step(1'b1, rand_win());
        end
        for (int i = 0; i < 48; i++) step(1'b1, rand_win());

        // Reset in the middle of a frame, then a full frame
        mode = 1'b1;
        for (int i = 0; i < 29; i++) step(1'b1, rand_win());
        do_reset();
        for (int i = 0; i < 48; i++) begin
            if ((i % 7) == 3) step(1'b0, 9'($urandom));
            step(1'b1, rand_win());
        end

        // All-ones erosion frame exposes border handling
        mode = 1'b0;
        for (int i = 0; i < 48; i++) step(1'b1, 9'h1FF);

        for (int i = 0; i < 3; i++) step(1'b0, 9'($urandom));
        check("scoreboard_drained", 16'(sb_q.size()), 16'd0);
        check("frame_done_count", 16'(done_cnt), 16'(done_exp));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
